// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: UART frame parser, per-channel command slots, motor dispatch.
// Define CMD_CHECKSUM_EN for 6-byte frames ending in an XOR checksum byte.
module motor_cmd_sequencer #(
   parameter int NCH    = 10,
   parameter int DIV_W  = 15,
   parameter int STEP_W = 13,
   parameter int RX_TO  = 4800,
   parameter int ACK_TO = 16
) (
   input  logic                    CLK,
   input  logic                    reset_n,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   input  logic [NCH-1:0]          mr_active,
   output logic [NCH*DIV_W-1:0]    mr_divider,
   output logic [NCH*STEP_W-1:0]   mr_steps,
   output logic [NCH-1:0]          pending,
   output logic [NCH-1:0]          busy,
   output logic [7:0]              err_cnt,
   output logic [1:0]              last_err
);

   localparam int TO_W  = $clog2(RX_TO + 1);
   localparam int ACK_W = $clog2(ACK_TO + 1);

   typedef enum logic [2:0] {
      P_ADDR, P_B0, P_B1, P_B2, P_B3
`ifdef CMD_CHECKSUM_EN
      , P_CHK
`endif
   } pstate_t;

   typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_RUN} dstate_t;

   pstate_t         pState;
   logic [3:0]      chR;
   logic [23:4]     payR;
   logic [TO_W-1:0] toCnt;
`ifdef CMD_CHECKSUM_EN
   logic [7:0]      b3R;
   logic [7:0]      xorR;
`endif

   logic            frameDone;
   logic            chValid;
   logic            chkOk;
   logic            rxTimeout;
   logic [31:4]     frameCmd;
   logic            errEv;
   logic [1:0]      errCode;
   logic [NCH-1:0]  consume;
   logic [NCH-1:0]  wrOk;
   logic [NCH-1:0]  slotBlk;

   always_comb begin
`ifdef CMD_CHECKSUM_EN
      frameDone = rx_valid && (pState == P_CHK);
      frameCmd  = {b3R, payR};
      chkOk     = (rx_data == xorR);
`else
      frameDone = rx_valid && (pState == P_B3);
      frameCmd  = {rx_data, payR};
      chkOk     = 1'b1;
`endif
      chValid   = ({1'b0, chR} < 5'(NCH));
      rxTimeout = (pState != P_ADDR) && !rx_valid &&
                  (toCnt == TO_W'(RX_TO - 1));
   end

   // At most one error source per cycle: a timeout excludes a frame end.
   always_comb begin
      errEv   = 1'b0;
      errCode = 2'd0;
      if (rxTimeout) begin
         errEv   = 1'b1;
         errCode = 2'd1;
      end else if (frameDone) begin
         if (!chValid) begin
            errEv   = 1'b1;
            errCode = 2'd0;
         end else if (!chkOk) begin
            errEv   = 1'b1;
            errCode = 2'd3;
         end else if (|slotBlk) begin
            errEv   = 1'b1;
            errCode = 2'd2;
         end
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         pState   <= P_ADDR;
         chR      <= '0;
         payR     <= '0;
         toCnt    <= '0;
         err_cnt  <= '0;
         last_err <= '0;
`ifdef CMD_CHECKSUM_EN
         b3R      <= '0;
         xorR     <= '0;
`endif
      end else begin
         if (rx_valid || pState == P_ADDR || rxTimeout)
            toCnt <= '0;
         else
            toCnt <= toCnt + TO_W'(1);
         if (errEv) begin
            last_err <= errCode;
            if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end
         if (rxTimeout) begin
            pState <= P_ADDR;
         end else if (rx_valid) begin
            case (pState)
               P_ADDR: begin
                  chR    <= rx_data[3:0];
                  pState <= P_B0;
`ifdef CMD_CHECKSUM_EN
                  xorR   <= rx_data;
`endif
               end
               P_B0: begin
                  payR[7:4] <= rx_data[7:4];
                  pState    <= P_B1;
`ifdef CMD_CHECKSUM_EN
                  xorR      <= xorR ^ rx_data;
`endif
               end
               P_B1: begin
                  payR[15:8] <= rx_data;
                  pState     <= P_B2;
`ifdef CMD_CHECKSUM_EN
                  xorR       <= xorR ^ rx_data;
`endif
               end
               P_B2: begin
                  payR[23:16] <= rx_data;
                  pState      <= P_B3;
`ifdef CMD_CHECKSUM_EN
                  xorR        <= xorR ^ rx_data;
`endif
               end
`ifdef CMD_CHECKSUM_EN
               P_B3: begin
                  b3R    <= rx_data;
                  xorR   <= xorR ^ rx_data;
                  pState <= P_CHK;
               end
               P_CHK:   pState <= P_ADDR;
`else
               P_B3:    pState <= P_ADDR;
`endif
               default: pState <= P_ADDR;
            endcase
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      dstate_t           dState;
      logic              pendR;
      logic              busyR;
      logic              hit;
      logic [DIV_W-1:0]  slotDiv;
      logic [DIV_W-1:0]  divR;
      logic [STEP_W-1:0] slotSteps;
      logic [STEP_W-1:0] stepsR;
      logic [ACK_W-1:0]  ackCnt;

      assign hit        = frameDone && chValid && chkOk && (chR == 4'(c));
      assign consume[c] = (dState == D_IDLE) && pendR && !mr_active[c];
      // A slot drained this very cycle counts as free for the incoming frame.
      assign wrOk[c]    = hit && (!pendR || consume[c]);
      assign slotBlk[c] = hit && pendR && !consume[c];

      always_ff @(posedge CLK or negedge reset_n) begin
         if (!reset_n) begin
            dState    <= D_IDLE;
            pendR     <= 1'b0;
            busyR     <= 1'b0;
            slotDiv   <= '0;
            slotSteps <= '0;
            divR      <= '0;
            stepsR    <= '0;
            ackCnt    <= '0;
         end else begin
            if (wrOk[c]) begin
               slotDiv   <= frameCmd[DIV_W+3:4];
               slotSteps <= frameCmd[31:32-STEP_W];
            end
            if (wrOk[c])
               pendR <= 1'b1;
            else if (consume[c])
               pendR <= 1'b0;
            case (dState)
               D_IDLE: begin
                  if (consume[c]) begin
                     divR   <= slotDiv;
                     stepsR <= slotSteps;
                     ackCnt <= '0;
                     busyR  <= 1'b1;
                     dState <= D_ISSUE;
                  end
               end
               D_ISSUE: begin
                  if (mr_active[c]) begin
                     dState <= D_RUN;
                  end else if (ackCnt == ACK_W'(ACK_TO - 1)) begin
                     stepsR <= '0;
                     busyR  <= 1'b0;
                     dState <= D_IDLE;
                  end else begin
                     ackCnt <= ackCnt + ACK_W'(1);
                  end
               end
               D_RUN: begin
                  if (!mr_active[c]) begin
                     stepsR <= '0;
                     busyR  <= 1'b0;
                     dState <= D_IDLE;
                  end
               end
               default: dState <= D_IDLE;
            endcase
         end
      end

      assign mr_divider[c*DIV_W +: DIV_W]  = divR;
      assign mr_steps[c*STEP_W +: STEP_W] = stepsR;
      assign pending[c]                   = pendR;
      assign busy[c]                      = busyR;
   end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: directed + randomized frames against a command-level model.
// Honours CMD_CHECKSUM_EN the same way as the design.
module tb_motor_cmd_sequencer;

   localparam int NCH    = 10;
   localparam int DIV_W  = 15;
   localparam int STEP_W = 13;
   localparam int RX_TO  = 4800;
   localparam int ACK_TO = 16;

   logic                  CLK = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  rx_valid = 1'b0;
   logic [7:0]            rx_data = 8'h00;
   logic [NCH-1:0]        mr_active = '0;
   logic [NCH*DIV_W-1:0]  mr_divider;
   logic [NCH*STEP_W-1:0] mr_steps;
   logic [NCH-1:0]        pending;
   logic [NCH-1:0]        busy;
   logic [7:0]            err_cnt;
   logic [1:0]            last_err;

   int checks = 0;
   int errors = 0;
   int errM = 0;
   int lastErrM = 0;

   motor_cmd_sequencer #(
      .NCH(NCH), .DIV_W(DIV_W), .STEP_W(STEP_W),
      .RX_TO(RX_TO), .ACK_TO(ACK_TO)
   ) dut (
      .CLK(CLK), .reset_n(reset_n), .rx_valid(rx_valid),
      .rx_data(rx_data), .mr_active(mr_active),
      .mr_divider(mr_divider), .mr_steps(mr_steps),
      .pending(pending), .busy(busy),
      .err_cnt(err_cnt), .last_err(last_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] divOf(input logic [31:0] cmd);
      return (cmd >> 4) % 32'h8000;
   endfunction

   function automatic logic [31:0] stepsOf(input logic [31:0] cmd);
      return cmd >> 19;
   endfunction

   function automatic logic [31:0] divAt(input int c);
      return 32'(mr_divider[c*DIV_W +: DIV_W]);
   endfunction

   function automatic logic [31:0] stepsAt(input int c);
      return 32'(mr_steps[c*STEP_W +: STEP_W]);
   endfunction

   task automatic noteErr(input int code);
      errM     = (errM < 255) ? errM + 1 : 255;
      lastErrM = code;
   endtask

   task automatic chkErr(input string tag);
      chk({tag, "_errcnt"}, 32'(err_cnt), errM);
      chk({tag, "_lasterr"}, 32'(last_err), lastErrM);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   // dropCh >= 0 releases that motor in the same cycle as the final byte
   task automatic sendFrame(input logic [7:0] addr, input logic [31:0] cmd,
                            input int dropCh);
      logic [7:0] b [5];
      b[0] = addr;
      b[1] = cmd[7:0];
      b[2] = cmd[15:8];
      b[3] = cmd[23:16];
      b[4] = cmd[31:24];
`ifdef CMD_CHECKSUM_EN
      for (int i = 0; i < 5; i++) sendByte(b[i]);
      if (dropCh >= 0) mr_active[dropCh] = 1'b0;
      sendByte(b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4]);
`else
      for (int i = 0; i < 4; i++) sendByte(b[i]);
      if (dropCh >= 0) mr_active[dropCh] = 1'b0;
      sendByte(b[4]);
`endif
   endtask

   initial begin : stim
      logic [31:0] cmd1, cmd2, cmd3, cA, cB;
      int ch, ack, runLen, chA, chB;

      tick(3);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_div", 32'(|mr_divider), 0);
      chk("rst_steps", 32'(|mr_steps), 0);
      chkErr("rst");
      reset_n = 1'b1;
      tick(2);

      cmd1 = 32'h0008_0010;
      sendFrame(8'h03, cmd1, -1);
      chk("f1_pending", 32'(pending[3]), 1);
      chk("f1_busy0", 32'(busy[3]), 0);
      tick(1);
      chk("f1_pending_clr", 32'(pending[3]), 0);
      chk("f1_busy", 32'(busy[3]), 1);
      chk("f1_div", divAt(3), 32'h1);
      chk("f1_steps", stepsAt(3), 32'h1);
      mr_active[3] = 1'b1;
      tick(2);
      chk("f1_run", 32'(busy[3]), 1);

      cmd2 = $urandom();
      sendFrame(8'h03, cmd2, -1);
      chk("f2_pending", 32'(pending[3]), 1);
      chk("f2_busy", 32'(busy[3]), 1);
      cmd3 = $urandom();
      sendFrame(8'h03, cmd3, -1);
      noteErr(2);
      chkErr("f3_ovf");
      chk("f3_pending", 32'(pending[3]), 1);

      mr_active[3] = 1'b0;
      tick(1);
      chk("fall_busy", 32'(busy[3]), 0);
      chk("fall_steps", stepsAt(3), 0);
      chk("fall_div", divAt(3), 32'h1);
      chk("fall_pending", 32'(pending[3]), 1);
      tick(1);
      chk("f2_issue_pend", 32'(pending[3]), 0);
      chk("f2_issue_busy", 32'(busy[3]), 1);
      chk("f2_div", divAt(3), divOf(cmd2));
      chk("f2_steps", stepsAt(3), stepsOf(cmd2));
      tick(ACK_TO - 2);
      chk("ack_wait_busy", 32'(busy[3]), 1);
      tick(3);
      chk("ack_to_busy", 32'(busy[3]), 0);
      chk("ack_to_steps", stepsAt(3), 0);
      chk("ack_to_div", divAt(3), divOf(cmd2));
      chkErr("ack_to");

      sendFrame(8'hAC, $urandom(), -1);
      noteErr(0);
      chkErr("badch");
      chk("badch_pending", 32'(pending), 0);
      cA = $urandom();
      sendFrame(8'h52, cA, -1);
      chk("upnib_pending", 32'(pending[2]), 1);
      tick(1);
      chk("upnib_div", divAt(2), divOf(cA));
      tick(ACK_TO + 1);
      chk("upnib_idle", 32'(busy[2]), 0);

      sendByte(8'h04);
      sendByte(8'h11);
      tick(RX_TO - 10);
      chkErr("pre_to");
      tick(12);
      noteErr(1);
      chkErr("rx_to");
      chk("rx_to_pending", 32'(pending), 0);
      cA = $urandom();
      sendFrame(8'h04, cA, -1);
      chk("post_to_pending", 32'(pending[4]), 1);
      tick(1);
      chk("post_to_steps", stepsAt(4), stepsOf(cA));
      tick(ACK_TO + 1);

      mr_active[5] = 1'b1;
      cA = $urandom();
      cB = $urandom();
      sendFrame(8'h05, cA, -1);
      tick(2);
      chk("held_pending", 32'(pending[5]), 1);
      chk("held_busy", 32'(busy[5]), 0);
      sendFrame(8'h05, cB, 5);
      chk("same_pending", 32'(pending[5]), 1);
      chk("same_busy", 32'(busy[5]), 1);
      chk("same_div", divAt(5), divOf(cA));
      chkErr("same");
      tick(ACK_TO);
      chk("same_idle_busy", 32'(busy[5]), 0);
      chk("same_idle_pend", 32'(pending[5]), 1);
      tick(1);
      chk("same_next_busy", 32'(busy[5]), 1);
      chk("same_next_div", divAt(5), divOf(cB));
      chk("same_next_steps", stepsAt(5), stepsOf(cB));
      tick(ACK_TO + 1);

      chA = 1;
      chB = 7;
      mr_active[chA] = 1'b1;
      mr_active[chB] = 1'b1;
      cA = $urandom();
      cB = $urandom();
      sendFrame(8'(chA), cA, -1);
      sendFrame(8'(chB), cB, -1);
      chk("dual_pending", 32'(pending), 32'((1 << chA) | (1 << chB)));
      mr_active[chA] = 1'b0;
      mr_active[chB] = 1'b0;
      tick(1);
      chk("dual_busy", 32'(busy), 32'((1 << chA) | (1 << chB)));
      chk("dual_divA", divAt(chA), divOf(cA));
      chk("dual_divB", divAt(chB), divOf(cB));
      tick(ACK_TO + 1);
      chk("dual_idle", 32'(busy), 0);

      for (int i = 0; i < 8; i++) begin
         ch     = $urandom_range(0, NCH - 1);
         cA     = $urandom();
         ack    = $urandom_range(0, 1);
         runLen = $urandom_range(1, 6);
         sendFrame({4'($urandom()), 4'(ch)}, cA, -1);
         chk("rnd_pending", 32'(pending[ch]), 1);
         tick(1);
         chk("rnd_busy", 32'(busy[ch]), 1);
         chk("rnd_div", divAt(ch), divOf(cA));
         chk("rnd_steps", stepsAt(ch), stepsOf(cA));
         if (ack != 0) begin
            mr_active[ch] = 1'b1;
            tick(runLen + ACK_TO);
            chk("rnd_run", 32'(busy[ch]), 1);
            mr_active[ch] = 1'b0;
            tick(1);
         end else begin
            tick(ACK_TO + 1);
         end
         chk("rnd_end_busy", 32'(busy[ch]), 0);
         chk("rnd_end_steps", stepsAt(ch), 0);
         chk("rnd_end_div", divAt(ch), divOf(cA));
         tick(1);
      end
      chkErr("rnd");

`ifdef CMD_CHECKSUM_EN
      cA = $urandom();
      for (int i = 0; i < 5; i++) sendByte(i == 0 ? 8'h08 : 8'(cA >> (8 * (i - 1))));
      sendByte(8'h08 ^ cA[7:0] ^ cA[15:8] ^ cA[23:16] ^ cA[31:24]);
      chk("chk_good", 32'(pending[8]), 1);
      tick(ACK_TO + 2);
      for (int i = 0; i < 5; i++) sendByte(i == 0 ? 8'h08 : 8'(cA >> (8 * (i - 1))));
      sendByte(8'h08 ^ cA[7:0] ^ cA[15:8] ^ cA[23:16] ^ cA[31:24] ^ 8'h01);
      noteErr(3);
      chkErr("chk_bad");
      chk("chk_bad_pend", 32'(pending[8]), 0);
`endif

      for (int i = 0; i < 260; i++) begin
         sendFrame({4'($urandom()), 4'($urandom_range(NCH, 15))}, $urandom(), -1);
         noteErr(0);
      end
      chkErr("sat");

      cA = $urandom() | 32'h0000_0010;
      sendFrame(8'h06, cA, -1);
      tick(1);
      mr_active[6] = 1'b1;
      tick(2);
      chk("pre_rst_busy", 32'(busy[6]), 1);
      sendByte(8'h01);
      sendByte(8'h22);
      #2 reset_n = 1'b0;
      #1;
      errM = 0;
      lastErrM = 0;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_pending", 32'(pending), 0);
      chk("arst_div", 32'(|mr_divider), 0);
      chk("arst_steps", 32'(|mr_steps), 0);
      chkErr("arst");
      mr_active = '0;
      @(negedge CLK);
      reset_n = 1'b1;
      tick(2);
      cB = $urandom();
      sendFrame(8'h01, cB, -1);
      chk("post_rst_pending", 32'(pending), 32'h2);
      chkErr("post_rst");
      tick(1);
      chk("post_rst_div", divAt(1), divOf(cB));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
